ysyx_25020047_ifu: RTL and testbench

Instruction fetch unit of the multi-cycle core: owns the PC, fetches one instruction per cycle-sequence from instruction memory over a valid/ready request/response interface, and hands it to decode. It is the consumer end of the write-back unit's next-PC output: after each instruction is issued, it waits for write-back to return `dnpc`, loads it into the PC and starts the next fetch. It also keeps a retired-instruction counter.

---
 rtl/ysyx_25020047_ifu.sv | 115 +++++++++++
 tb/tb_ysyx_25020047_ifu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: owns the PC and runs a REQ/WAIT/HOLD/EXEC loop per instruction.
// Optional YSYX_25020047_IFU_ALIGN_CHECK_EN halts on a misaligned next-PC instead of masking it.
module ysyx_25020047_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        wb_valid,
    input  logic [31:0] wb_dnpc,
    output logic [31:0] retire_cnt,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_EXEC = 3'd3,
        S_HALT = 3'd4
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] retire_cnt_q;
    logic [31:0] dnpc_aligned;

    assign dnpc_aligned = {wb_dnpc[31:2], 2'b00};

`ifdef YSYX_25020047_IFU_ALIGN_CHECK_EN
    logic fetch_err_q;
    logic dnpc_misaligned;

    assign dnpc_misaligned = |wb_dnpc[1:0];
    assign fetch_err       = fetch_err_q;
`else
    // Low bits are discarded when the target is forced onto a word boundary.
    logic dnpc_lsb_unused;

    assign dnpc_lsb_unused = ^wb_dnpc[1:0];
    assign fetch_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            retire_cnt_q <= 32'h0;
`ifdef YSYX_25020047_IFU_ALIGN_CHECK_EN
            fetch_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_q  <= imem_rsp_data;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (wb_valid) begin
                        retire_cnt_q <= retire_cnt_q + 32'd1;
`ifdef YSYX_25020047_IFU_ALIGN_CHECK_EN
                        // The offending instruction still retires; the PC keeps pointing at it.
                        if (dnpc_misaligned) begin
                            fetch_err_q <= 1'b1;
                            state_q     <= S_HALT;
                        end else begin
                            pc_q    <= dnpc_aligned;
                            state_q <= S_REQ;
                        end
`else
                        pc_q    <= dnpc_aligned;
                        state_q <= S_REQ;
`endif
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign inst           = inst_q;
    assign pc             = pc_q;
    assign retire_cnt     = retire_cnt_q;

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Scoreboard bench for ysyx_25020047_ifu: directed fetch sequences, a negedge monitor
// pops expected request addresses and decode handshakes from queues.
module tb_ysyx_25020047_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wb_valid;
    logic [31:0] wb_dnpc;
    logic [31:0] retire_cnt;
    logic        fetch_err;

    ysyx_25020047_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .wb_valid       (wb_valid),
        .wb_dnpc        (wb_dnpc),
        .retire_cnt     (retire_cnt),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] ret;
    } inst_exp_t;

    logic [31:0] req_q[$];
    inst_exp_t   inst_q[$];
    int          hs_cycles[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_retire = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs change at posedge+1, so the negedge sees the values the next edge will use.
    logic        req_pend = 1'b0;
    logic [31:0] req_hold = 32'h0;
    logic        inst_pend = 1'b0;
    logic [31:0] inst_hold = 32'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_pend  = 1'b0;
            inst_pend = 1'b0;
        end else begin
            if (req_pend) begin
                check("req_valid_stable", 32'(imem_req_valid), 32'd1);
                check("req_addr_stable", imem_addr, req_hold);
            end
            if (inst_pend) begin
                check("inst_valid_stable", 32'(inst_valid), 32'd1);
                check("inst_stable", inst, inst_hold);
            end
            if (imem_req_valid && imem_req_ready) begin
                hs_cycles.push_back(cyc);
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
                end else begin
                    logic [31:0] ea;
                    ea = req_q.pop_front();
                    check("req_addr", imem_addr, ea);
                end
            end
            if (inst_valid && inst_ready) begin
                if (inst_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_inst: got inst %h expected no issue", inst);
                end else begin
                    inst_exp_t e;
                    e = inst_q.pop_front();
                    check("issue_inst", inst, e.data);
                    check("issue_pc", pc, e.pc);
                    check("issue_retire", retire_cnt, e.ret);
                end
            end
            req_pend  = imem_req_valid && !imem_req_ready;
            req_hold  = imem_addr;
            inst_pend = inst_valid && !inst_ready;
            inst_hold = inst;
        end
    end

    // One full instruction; starts and ends at posedge+1 with the DUT expected in REQ.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int req_stall, input int rsp_delay, input int dec_stall,
                         input int wb_delay, input bit spurious, input bit wrap,
                         input logic [31:0] dnpc);
        inst_exp_t e;
        e.pc = addr;
        e.data = data;
        e.ret = exp_retire;
        req_q.push_back(addr);
        inst_q.push_back(e);
        imem_req_ready = 1'b0;
        repeat (req_stall) tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < rsp_delay; i++) begin
            if (spurious) begin
                wb_valid = 1'b1;
                wb_dnpc  = 32'h1234_5678;
            end
            tick();
        end
        wb_valid = 1'b0;
        check("wait_pc_hold", pc, addr);
        check("wait_no_req", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        check("inst_latched", inst, data);
        for (int i = 0; i < dec_stall; i++) begin
            if (spurious) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            tick();
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        if (wrap) begin
            force dut.retire_cnt_q = 32'hFFFF_FFFF;
            #1;
            release dut.retire_cnt_q;
            exp_retire = 32'hFFFF_FFFF;
        end
        repeat (wb_delay) tick();
        wb_valid = 1'b1;
        wb_dnpc  = dnpc;
        tick();
        wb_valid = 1'b0;
        wb_dnpc  = 32'h0;
        exp_retire = exp_retire + 32'd1;
        check("retire_cnt", retire_cnt, exp_retire);
    endtask

    initial begin
        int n0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        wb_valid       = 1'b0;
        wb_dnpc        = 32'h0;

        repeat (2) tick();
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_retire", retire_cnt, 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_addr", imem_addr, 32'h8000_0000);

        // Reset while waiting for the response.
        req_q.push_back(32'h8000_0000);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("wait_req_low", 32'(imem_req_valid), 32'd0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst_pc", pc, 32'h8000_0000);
        check("midwait_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("midwait_rst_retire", retire_cnt, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rerst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rerst_addr", imem_addr, 32'h8000_0000);

        // Zero-wait back-to-back: request handshakes 4 cycles apart.
        n0 = hs_cycles.size();
        fetch(32'h8000_0000, 32'h0000_0413, 0, 0, 0, 0, 1'b0, 1'b0, 32'h8000_0004);
        check("next_addr", imem_addr, 32'h8000_0004);
        fetch(32'h8000_0004, 32'h0010_0093, 0, 0, 0, 0, 1'b0, 1'b0, 32'h8000_0008);
        check("hs_count", 32'(hs_cycles.size()), 32'(n0 + 2));
        check("loop_cycles", 32'(hs_cycles[n0 + 1] - hs_cycles[n0]), 32'd4);

        // Backpressure on request and decode.
        fetch(32'h8000_0008, 32'hFFF0_0113, 3, 1, 2, 1, 1'b0, 1'b0, 32'h8000_000C);

        // Spurious write-back during WAIT, spurious response during HOLD.
        fetch(32'h8000_000C, 32'h0020_81B3, 0, 2, 2, 0, 1'b1, 1'b0, 32'h8000_0010);

        // Counter wrap with a jump.
        fetch(32'h8000_0010, 32'h0F00_006F, 0, 0, 0, 1, 1'b0, 1'b1, 32'h8000_0100);
        check("wrap_retire_zero", retire_cnt, 32'h0);
        check("jump_addr", imem_addr, 32'h8000_0100);

        // Misaligned target.
        fetch(32'h8000_0100, 32'h0020_0113, 0, 0, 0, 0, 1'b0, 1'b0, 32'h8000_0102);
`ifdef YSYX_25020047_IFU_ALIGN_CHECK_EN
        begin
            logic seen;
            seen = 1'b0;
            check("misalign_err", 32'(fetch_err), 32'd1);
            check("misalign_pc", pc, 32'h8000_0100);
            imem_req_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                seen = seen | imem_req_valid | inst_valid;
                tick();
            end
            imem_req_ready = 1'b0;
            check("halt_quiet", 32'(seen), 32'd0);
            check("halt_err_sticky", 32'(fetch_err), 32'd1);
        end
`else
        check("misalign_no_err", 32'(fetch_err), 32'd0);
        check("misalign_masked_addr", imem_addr, 32'h8000_0100);
        fetch(32'h8000_0100, 32'h0000_0073, 0, 0, 0, 0, 1'b0, 1'b0, 32'h8000_0104);
`endif
        repeat (3) tick();
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("inst_q_drained", 32'(inst_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
